// File: rtl/cam_frame_write_scheduler_pkg.sv
// Shared types and constants for the camera frame write scheduler.
package cam_sched_pkg;

  // Scheduler states
  typedef enum logic [2:0] {
    IDLE,
    SEEK_SOF,
    FILL,
    REQ,
    BURST
  } state_e;

  // Camera FIFO word layout
  localparam int CAM_SOF_BIT = 16;
  localparam int CAM_PIX_MSB = 15;
  localparam int CAM_WORD_W  = CAM_SOF_BIT + 1;

  // Frame pixel counter width
  localparam int PIX_CNT_W = 20;

  // Logger verbosity levels
  localparam int SVL_VERBOSE_NONE  = 0;
  localparam int SVL_VERBOSE_ERROR = 1;
  localparam int SVL_VERBOSE_WARN  = 2;
  localparam int SVL_VERBOSE_INFO  = 3;

  typedef struct packed {
    logic                 sof;
    logic [CAM_PIX_MSB:0] pixel;
  } cam_word_t;

endpackage

// File: rtl/cam_frame_write_scheduler_if.sv
// FIFO read side and memory write side of the frame write scheduler.
// master: the scheduler; slave: the FIFO/memory controller side.
interface cam_frame_write_scheduler_if #(
  parameter int ADDR_WIDTH = 21
) ();
  import cam_sched_pkg::*;

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  cam_word_t             fifo_data;
  logic                  mem_wr_req;
  logic                  mem_wr_ack;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wr_data;
  logic                  mem_wr_valid;
  logic                  frame_done;
  logic                  sync_err;
  logic                  frame_buf_sel;

  modport master (
    input  fifo_empty, fifo_data, mem_wr_ack,
    output fifo_rd_en, mem_wr_req, mem_addr, mem_wr_data, mem_wr_valid,
    output frame_done, sync_err, frame_buf_sel
  );

  modport slave (
    output fifo_empty, fifo_data, mem_wr_ack,
    input  fifo_rd_en, mem_wr_req, mem_addr, mem_wr_data, mem_wr_valid,
    input  frame_done, sync_err, frame_buf_sel
  );

endinterface

// File: rtl/cam_frame_write_scheduler_burst_buffer.sv
// cam_burst_buffer: BURST_WORDS x 16 staging array for one memory burst.
// Write pointer counts stored words (0..BURST_WORDS); read pointer walks
// the array during the burst. clr_i together with wr_en_i restarts the
// buffer with the incoming word at index 0.
module cam_burst_buffer
  import cam_sched_pkg::*;
#(
  parameter int BURST_WORDS = 32
) (
  input  logic                           clk,
  input  logic                           nRST,
  input  logic                           clr_i,
  input  logic                           wr_en_i,
  input  logic [CAM_PIX_MSB:0]           wr_data_i,
  input  logic                           rd_adv_i,
  output logic [CAM_PIX_MSB:0]           rd_data_o,
  output logic [$clog2(BURST_WORDS):0]   count_o,
  output logic                           full_o,
  output logic                           last_o
);

  localparam int PTR_W = $clog2(BURST_WORDS);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(BURST_WORDS);
  localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BURST_WORDS - 1);
  localparam logic [PTR_W-1:0] ONE_IDX  = PTR_W'(1);

  logic [CAM_PIX_MSB:0] mem_q [BURST_WORDS];
  logic [PTR_W:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [PTR_W-1:0]     waddr;
  logic                 we;

  assign full_o    = (wptr_q == FULL_CNT);
  assign last_o    = (rptr_q == LAST_IDX);
  assign count_o   = wptr_q;
  assign rd_data_o = mem_q[rptr_q];
  assign we        = wr_en_i && (clr_i || !full_o);
  assign waddr     = clr_i ? '0 : wptr_q[PTR_W-1:0];

  // Pointer next-state: clear wins, a write during clear lands at index 0
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr_i) begin
      wptr_d = wr_en_i ? ONE_CNT : '0;
      rptr_d = '0;
    end else begin
      if (we)       wptr_d = wptr_q + ONE_CNT;
      if (rd_adv_i) rptr_d = rptr_q + ONE_IDX;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Data array, no reset needed: contents are only read after being written
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wr_data_i;
  end

endmodule

// File: rtl/cam_frame_write_scheduler.sv
// cam_frame_write_scheduler: drains the camera FIFO into fixed-length
// burst writes to the frame buffer, tracking the frame address and
// resynchronising on start-of-frame.
// Optional: define CAM_DOUBLE_BUFFER_EN to alternate between two frame
// buffers (FRAME_BASE_0 / FRAME_BASE_1) on each completed frame.
module cam_frame_write_scheduler
  import cam_sched_pkg::*;
#(
  parameter int                    FRAME_WIDTH  = 640,
  parameter int                    FRAME_HEIGHT = 480,
  parameter int                    BURST_WORDS  = 32,
  parameter int                    ADDR_WIDTH   = 21,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE_0 = 21'h000000,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE_1 = 21'h080000,
  parameter int                    LOG_LEVEL    = SVL_VERBOSE_INFO
) (
  input  logic                          clk,
  input  logic                          nRST,
  input  logic                          enable,
  cam_frame_write_scheduler_if.master   bus
);

  localparam int PTR_W = $clog2(BURST_WORDS);
  localparam logic [PIX_CNT_W-1:0] FRAME_PIX = PIX_CNT_W'(FRAME_WIDTH * FRAME_HEIGHT);
  localparam logic [PIX_CNT_W-1:0] BURST_INC = PIX_CNT_W'(BURST_WORDS);
  localparam logic [PTR_W:0]       LAST_CNT  = (PTR_W+1)'(BURST_WORDS - 1);
  localparam logic [PTR_W:0]       FULL_CNT  = (PTR_W+1)'(BURST_WORDS);

  state_e                 state_q, state_d;
  logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d, pix_nxt;
  logic                   rd_vld_q;     // read issued last cycle: fifo_data valid now
  logic                   frame_done_q, frame_done_d;
  logic                   sync_err_q, sync_err_d;
  logic                   buf_sel_q, buf_sel_d;
  logic [ADDR_WIDTH-1:0]  base;
  logic                   unused_cfg;

  logic                   rd_en, mem_req, mem_vld;
  logic                   buf_clr, buf_wr, buf_adv;
  logic [CAM_PIX_MSB:0]   buf_rdata;
  logic [PTR_W:0]         buf_cnt;
  logic                   buf_full, buf_last;
  cam_word_t              rd_word;

  assign rd_word = bus.fifo_data;
  assign pix_nxt = pix_cnt_q + BURST_INC;

`ifdef CAM_DOUBLE_BUFFER_EN
  assign base       = buf_sel_q ? FRAME_BASE_1 : FRAME_BASE_0;
  assign unused_cfg = ^LOG_LEVEL;
`else
  assign base       = FRAME_BASE_0;
  assign unused_cfg = ^{FRAME_BASE_1, LOG_LEVEL};
`endif

  cam_burst_buffer #(.BURST_WORDS(BURST_WORDS)) u_buf (
    .clk       (clk),
    .nRST      (nRST),
    .clr_i     (buf_clr),
    .wr_en_i   (buf_wr),
    .wr_data_i (rd_word.pixel),
    .rd_adv_i  (buf_adv),
    .rd_data_o (buf_rdata),
    .count_o   (buf_cnt),
    .full_o    (buf_full),
    .last_o    (buf_last)
  );

  // Next-state, FIFO read control and burst sequencing
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    buf_sel_d    = buf_sel_q;
    rd_en        = 1'b0;
    mem_req      = 1'b0;
    mem_vld      = 1'b0;
    buf_clr      = 1'b0;
    buf_wr       = 1'b0;
    buf_adv      = 1'b0;
    case (state_q)
      IDLE: begin
        pix_cnt_d = '0;
        buf_clr   = 1'b1;
        if (enable) state_d = SEEK_SOF;
      end
      SEEK_SOF: begin
        if (!enable) begin
          buf_clr = 1'b1;
          state_d = IDLE;
        end else begin
          rd_en = !bus.fifo_empty;
          // Non-SOF words are dropped; SOF is frame pixel 0
          if (rd_vld_q && rd_word.sof) begin
            buf_wr  = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (!enable) begin
          buf_clr = 1'b1;
          state_d = IDLE;
        end else begin
          // Count the in-flight read so the buffer is never over-filled
          rd_en = !bus.fifo_empty && !buf_full &&
                  ((buf_cnt + (PTR_W+1)'(rd_vld_q)) < FULL_CNT);
          if (rd_vld_q) begin
            buf_wr = 1'b1;
            if (rd_word.sof) begin
              // Early SOF: drop the partial burst and restart the frame
              sync_err_d = 1'b1;
              pix_cnt_d  = '0;
              buf_clr    = 1'b1;
            end else if (buf_cnt == LAST_CNT) begin
              state_d = REQ;
            end
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (bus.mem_wr_ack) state_d = BURST;
      end
      BURST: begin
        mem_vld = 1'b1;
        buf_adv = 1'b1;
        if (buf_last) begin
          buf_clr = 1'b1;
          if (pix_nxt == FRAME_PIX) begin
            pix_cnt_d    = '0;
            frame_done_d = 1'b1;
`ifdef CAM_DOUBLE_BUFFER_EN
            buf_sel_d    = ~buf_sel_q;
`endif
            state_d      = enable ? SEEK_SOF : IDLE;
          end else begin
            pix_cnt_d = pix_nxt;
            state_d   = enable ? FILL : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and status registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      pix_cnt_q    <= '0;
      rd_vld_q     <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      buf_sel_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      rd_vld_q     <= rd_en;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      buf_sel_q    <= buf_sel_d;
    end
  end

  assign bus.fifo_rd_en    = rd_en;
  assign bus.mem_wr_req    = mem_req;
  assign bus.mem_addr      = base + ADDR_WIDTH'(pix_cnt_q);
  assign bus.mem_wr_valid  = mem_vld;
  assign bus.mem_wr_data   = mem_vld ? buf_rdata : '0;
  assign bus.frame_done    = frame_done_q;
  assign bus.sync_err      = sync_err_q;
  assign bus.frame_buf_sel = buf_sel_q;

endmodule

// File: tb/tb_cam_frame_write_scheduler.sv
// Self-checking bench for cam_frame_write_scheduler (small 16x8 frame).
// Honours CAM_DOUBLE_BUFFER_EN for the expected frame-2 addresses.
module tb_cam_frame_write_scheduler;
  import cam_sched_pkg::*;

  localparam int FW = 16, FH = 8, BW = 32, AW = 21, FP = FW * FH;
  localparam logic [AW-1:0] B0 = 21'h000000;
  localparam logic [AW-1:0] B1 = 21'h080000;
`ifdef CAM_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic clk = 1'b0;
  logic nRST, enable;
  cam_frame_write_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

  cam_frame_write_scheduler #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .BURST_WORDS(BW), .ADDR_WIDTH(AW),
    .FRAME_BASE_0(B0), .FRAME_BASE_1(B1), .LOG_LEVEL(SVL_VERBOSE_INFO)
  ) dut (
    .clk(clk), .nRST(nRST), .enable(enable), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // ---------------- FIFO model ----------------
  logic [16:0] fq[$];
  bit starve_en = 1'b0;
  logic starve_ph;
  int underflow = 0;

  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      bus.fifo_data  <= '0;
      bus.fifo_empty <= 1'b1;
      starve_ph      <= 1'b0;
    end else begin
      if (bus.fifo_rd_en) begin
        if (bus.fifo_empty || fq.size() == 0) underflow <= underflow + 1;
        else bus.fifo_data <= fq.pop_front();
      end
      starve_ph      <= ~starve_ph;
      bus.fifo_empty <= (fq.size() == 0) || (starve_en && !starve_ph);
    end
  end

  // ---------------- memory controller model ----------------
  int ack_dly = 0, ack_cnt = 0;
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      bus.mem_wr_ack <= 1'b0;
      ack_cnt        <= 0;
    end else begin
      bus.mem_wr_ack <= 1'b0;
      if (bus.mem_wr_req && !bus.mem_wr_ack) begin
        if (ack_cnt >= ack_dly) begin
          bus.mem_wr_ack <= 1'b1;
          ack_cnt        <= 0;
        end else ack_cnt <= ack_cnt + 1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [AW-1:0] addr_q[$];
  logic [15:0]   data_q[$];
  logic          sel_at_fd[$];
  int run = 0, bad_run = 0, fd_cnt = 0, fd_bad = 0, se_cnt = 0;
  logic prev_vld = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_wr_req && bus.mem_wr_ack) addr_q.push_back(bus.mem_addr);
    if (bus.mem_wr_valid) begin
      data_q.push_back(bus.mem_wr_data);
      run <= run + 1;
    end else if (run != 0) begin
      if (run != BW) bad_run <= bad_run + 1;
      run <= 0;
    end
    if (bus.frame_done) begin
      fd_cnt <= fd_cnt + 1;
      if (!prev_vld) fd_bad <= fd_bad + 1;
      sel_at_fd.push_back(bus.frame_buf_sel);
    end
    if (bus.sync_err) se_cnt <= se_cnt + 1;
    prev_vld <= bus.mem_wr_valid;
  end

  task automatic push(input int n, input int sof_idx, input logic [15:0] base);
    for (int i = 0; i < n; i++) fq.push_back({(i == sof_idx), 16'(base + 16'(i))});
  endtask

  // wait until at least nw words written and the burst has ended
  task automatic wait_words(input int nw, input int budget, input string nm);
    int c;
    c = 0;
    while ((data_q.size() < nw || bus.mem_wr_valid) && c <= budget) begin
      @(negedge clk);
      c++;
    end
    if (c > budget) tmo(nm);
  endtask

  typedef struct {
    int          n;
    int          sof_idx;
    logic [15:0] base;
    int          ack;
    bit          starve;
    logic [AW-1:0] exp_addr;
    logic [15:0] exp_first;
    int          exp_se;
  } vec_t;

  vec_t vt[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, a0, s0, f0, bad, c;
    logic [15:0] e;
    logic [AW-1:0] ea;

    // 3 junk + SOF frame start, steady bursts, starved FIFO, early SOF at
    // frame pixel 100, then a burst after the resync
    vt[0] = '{35, 3,  16'hFFFD, 0, 1'b0, 21'h00000, 16'h0000, 0};
    vt[1] = '{32, -1, 16'h0100, 2, 1'b0, 21'h00020, 16'h0100, 0};
    vt[2] = '{32, -1, 16'h0200, 0, 1'b1, 21'h00040, 16'h0200, 0};
    vt[3] = '{36, 4,  16'h0300, 1, 1'b0, 21'h00000, 16'h0304, 1};
    vt[4] = '{32, -1, 16'h0400, 1, 1'b1, 21'h00020, 16'h0400, 0};

    nRST = 1'b1;
    enable = 1'b0;
    #2 nRST = 1'b0;
    repeat (2) @(negedge clk);
    check("rst mem_wr_req",    32'(bus.mem_wr_req), 0);
    check("rst mem_wr_valid",  32'(bus.mem_wr_valid), 0);
    check("rst fifo_rd_en",    32'(bus.fifo_rd_en), 0);
    check("rst frame_done",    32'(bus.frame_done), 0);
    check("rst sync_err",      32'(bus.sync_err), 0);
    check("rst frame_buf_sel", 32'(bus.frame_buf_sel), 0);
    check("rst mem_wr_data",   32'(bus.mem_wr_data), 0);
    check("rst mem_addr",      32'(bus.mem_addr), 32'(B0));
    nRST = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    // ---------- table-driven bursts ----------
    for (int v = 0; v < 5; v++) begin
      w0 = data_q.size();
      a0 = addr_q.size();
      s0 = se_cnt;
      ack_dly   = vt[v].ack;
      starve_en = vt[v].starve;
      push(vt[v].n, vt[v].sof_idx, vt[v].base);
      wait_words(w0 + BW, 600, $sformatf("vec%0d burst", v));
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d burst count", v), 32'(addr_q.size() - a0), 1);
      check($sformatf("vec%0d mem_addr", v), (addr_q.size() > a0) ? 32'(addr_q[a0]) : 32'hFFFF_FFFF,
            32'(vt[v].exp_addr));
      bad = 0;
      for (int k = 0; k < BW; k++) begin
        e = vt[v].exp_first + 16'(k);
        if (w0 + k >= data_q.size() || data_q[w0 + k] !== e) bad++;
      end
      check($sformatf("vec%0d data mismatches", v), 32'(bad), 0);
      check($sformatf("vec%0d sync_err pulses", v), 32'(se_cnt - s0), 32'(vt[v].exp_se));
    end
    starve_en = 1'b0;
    check("no frame_done mid-frame", 32'(fd_cnt), 0);

    // ---------- enable dropped mid-BURST ----------
    w0 = data_q.size();
    a0 = addr_q.size();
    ack_dly = 0;
    push(32, -1, 16'h0500);
    c = 0;
    while (!bus.mem_wr_valid && c < 300) begin @(negedge clk); c++; end
    if (c >= 300) tmo("drop: burst start");
    repeat (5) @(negedge clk);
    enable = 1'b0;
    wait_words(w0 + BW, 100, "drop: burst end");
    check("drop: words in burst", 32'(data_q.size() - w0), 32'(BW));
    check("drop: burst addr", (addr_q.size() > a0) ? 32'(addr_q[a0]) : 32'hFFFF_FFFF, 32'h40);
    push(5, 0, 16'h0600);
    repeat (20) @(negedge clk);
    check("drop: FIFO untouched in IDLE", 32'(fq.size()), 5);
    check("drop: no request in IDLE", 32'(bus.mem_wr_req), 0);

    // ---------- reset asserted mid-REQ (second burst, addr 0x20) ----------
    fq.delete();
    ack_dly = 6;
    a0 = addr_q.size();
    enable = 1'b1;
    push(64, 0, 16'h3000);
    c = 0;
    while (!(addr_q.size() == a0 + 1 && bus.mem_wr_req) && c < 600) begin @(negedge clk); c++; end
    if (c >= 600) tmo("rstreq: second request");
    check("rstreq: addr before reset", 32'(bus.mem_addr), 32'h20);
    nRST = 1'b0;
    #1;
    check("rstreq: mem_wr_req", 32'(bus.mem_wr_req), 0);
    check("rstreq: mem_wr_valid", 32'(bus.mem_wr_valid), 0);
    check("rstreq: mem_addr", 32'(bus.mem_addr), 32'(B0));
    fq.delete();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);

    // ---------- two complete frames ----------
    w0 = data_q.size();
    a0 = addr_q.size();
    f0 = fd_cnt;
    s0 = se_cnt;
    ack_dly = 2;
    enable = 1'b1;
    push(2 + FP, 2, 16'h1000);
    push(1 + FP, 1, 16'h2000);
    wait_words(w0 + 2 * FP, 3000, "frames: data");
    repeat (3) @(negedge clk);
    check("frames: burst count", 32'(addr_q.size() - a0), 32'(2 * FP / BW));
    for (int b = 0; b < 2 * FP / BW; b++) begin
      ea = ((b < FP / BW) ? B0 : (DB ? B1 : B0)) + AW'(BW * (b % (FP / BW)));
      check($sformatf("frames: burst%0d addr", b),
            (addr_q.size() > a0 + b) ? 32'(addr_q[a0 + b]) : 32'hFFFF_FFFF, 32'(ea));
    end
    bad = 0;
    for (int k = 0; k < 2 * FP; k++) begin
      e = (k < FP) ? 16'(16'h1002 + k) : 16'(16'h2001 + k - FP);
      if (w0 + k >= data_q.size() || data_q[w0 + k] !== e) bad++;
    end
    check("frames: data mismatches", 32'(bad), 0);
    check("frames: frame_done pulses", 32'(fd_cnt - f0), 2);
    check("frames: frame_done after last valid", 32'(fd_bad), 0);
    check("frames: sync_err pulses", 32'(se_cnt - s0), 0);
    check("frames: sel after frame 1", (sel_at_fd.size() > f0) ? 32'(sel_at_fd[f0]) : 32'hFFFF_FFFF,
          32'(DB));
    check("frames: sel after frame 2", (sel_at_fd.size() > f0 + 1) ? 32'(sel_at_fd[f0 + 1]) : 32'hFFFF_FFFF,
          0);

    // ---------- global invariants ----------
    check("all bursts exactly BW valid cycles", 32'(bad_run), 0);
    check("no read while empty", 32'(underflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
